video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator. Counts a configurable video frame and produces hs, vs, de, per-pixel coordinates and frame/line markers. Coordinates and a fetch request run a programmable number of cycles ahead of de, so a frame-buffer or line-buffer read with fixed latency lands exactly on the active pixel. It has a clock enable and a synchronous frame restart for locking to an external source. It sits between the pixel-clock domain and the video encoder (DVI/HDMI TMDS path).

## Interface
- CNT_W, 12: width of internal counters and of active_x/active_y; must hold H_TOTAL-1 and V_TOTAL-1
- H_ACTIVE, 1280: active pixels per line
- H_FP, 110: horizontal front porch, pixels
- H_SYNC, 40: hsync width, pixels
- H_BP, 220: horizontal back porch, pixels
- V_ACTIVE, 720: active lines
- V_FP, 5: vertical front porch, lines
- V_SYNC, 5: vsync width, lines
- V_BP, 20: vertical back porch, lines
- HS_POL, 1: hs asserted level (1 positive, 0 negative)
- VS_POL, 1: vs asserted level
- PREFETCH, 0: cycles by which req/active_x/active_y lead de; range 0..7
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; low = every register holds
- restart  in  1  synchronous restart to the start of the frame
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  data enable, active pixel
- frame_start  out  1  high with de on pixel (0,0) of each frame
- line_start  out  1  high with de on pixel x=0 of each active line
- req  out  1  fetch request; active position, PREFETCH cycles ahead of de
- active_x  out  CNT_W  x coordinate of the req position
- active_y  out  CNT_W  y coordinate of the req position

## Operation
- Derived constants: H_BLANK=H_FP+H_SYNC+H_BP, H_TOTAL=H_BLANK+H_ACTIVE; V_BLANK and V_TOTAL are defined the same way.
- Line layout by h_cnt: [0,H_FP) front porch; [H_FP,H_FP+H_SYNC) sync; up to H_BLANK back porch; [H_BLANK,H_TOTAL) active. Frame layout by v_cnt uses the same order with the V_* values.
- Counters:
  - h_cnt wraps H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt=H_TOTAL-1, and wraps V_TOTAL-1 to 0.
  - Both advance only when en=1.
- Per position:
  - act = (h_cnt>=H_BLANK) && (v_cnt>=V_BLANK)
  - hsync_on = h_cnt in sync range
  - vsync_on = v_cnt in sync range; it changes only at h_cnt=0
- Stage 1 (registered from the counters):
  - req=act
  - when act: active_x=h_cnt-H_BLANK and active_y=v_cnt-V_BLANK, CNT_W-bit unsigned
  - when not act: active_x/active_y hold their last value
- Stage 2: a delay line of PREFETCH enabled cycles carries {act, hsync_on, vsync_on, first-pixel, first-of-line} from stage 1 to the outputs.
  - hs = hsync_on ? HS_POL : ~HS_POL; vs is formed the same way with VS_POL.
  - de = act.
  - frame_start = act at x=0,y=0; line_start = act at x=0.
  - PREFETCH=0 means stage 2 is a wire.
- en=0: counters, stage 1, delay line and all outputs hold. Pulse outputs are one enabled cycle wide, so consumers qualify them with en.
- restart=1, at any clock edge and regardless of en:
  - counters go to (0,0)
  - req=0, and the delay line fills with blank/idle (act=0, syncs deasserted, markers 0)
  - active_x/active_y hold
  - If restart is held, the block stays in this state.

## Timing
- Reset values: hs=~HS_POL, vs=~VS_POL, de=0, req=0, frame_start=0, line_start=0, active_x=0, active_y=0. Counters are (0,0) and the delay line is blank/idle.
- Position n is the counter value during the n-th enabled cycle after reset or restart, with n=0 being (0,0).
  - req, active_x and active_y describe position n in the enabled cycle n+1.
  - de, hs, vs and the markers describe position n in enabled cycle n+1+PREFETCH.
- req leads de by exactly PREFETCH enabled cycles on every edge, rising and falling.
- hs width is H_SYNC enabled cycles. vs width is V_SYNC*H_TOTAL enabled cycles, with edges coincident with h_cnt=0 positions.
- Frame period is H_TOTAL*V_TOTAL enabled cycles. There are H_ACTIVE*V_ACTIVE de cycles per frame.
- Asynchronous reset mid-frame forces the reset values immediately. The first frame after release starts at position (0,0).
- Wrap-around: active_x/active_y never exceed H_ACTIVE-1/V_ACTIVE-1. Counters never reach H_TOTAL/V_TOTAL.

## Test plan
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, CNT_W=6, which gives H_TOTAL=14, V_TOTAL=8 and a 112-cycle frame.

1. Reset held 5 cycles, en=1:
   - During reset, outputs hold the reset values.
   - With PREFETCH=0, the first de rises 63 cycles after release (position (6,4), seen at cycle 63).
   - hs is high for 3 cycles starting at cycle 3.
2. Free-run 3 frames, PREFETCH=0:
   - 32 de cycles per frame, as 4 bursts of 8 with x=0..7 and y=0..3.
   - vs is high for 28 cycles per frame.
   - frame_start occurs once every 112 cycles.
   - line_start occurs 4 times per frame.
3. PREFETCH=3:
   - Every req rise and fall is exactly 3 cycles before the matching de edge.
   - active_x steps 0..7 while req=1.
   - hs/vs/markers are shifted 3 cycles relative to scenario 2.
4. en toggled in a random pattern:
   - All outputs are frozen while en=0.
   - Exactly 112 enabled cycles pass between frame_start pulses.
   - The de count per frame is still 32.
5. restart pulsed at position (9,5):
   - The next cycle shows req=0; after PREFETCH cycles, de=0 with hs/vs idle.
   - The next frame_start follows 63+PREFETCH enabled cycles after the restart edge.
   - Repeat with restart held for 10 cycles and with restart coinciding with en=0.
6. HS_POL=0, VS_POL=0:
   - hs/vs waveforms are inverted and reset to 1.
   - Assert rst mid-active-line: outputs go to reset values asynchronously, and timing matches scenario 1 after release.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with sync/de/marker outputs and a
// fetch request plus coordinates that lead de by PREFETCH enabled cycles.
module video_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PREFETCH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             frame_start,
  output logic             line_start,
  output logic             req,
  output logic [CNT_W-1:0] active_x,
  output logic [CNT_W-1:0] active_y
);
  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;
  localparam logic [CNT_W-1:0] HB  = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] HT1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VB  = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] VT1 = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic act, hsync_on, vsync_on, first_px, first_ln;
  logic [4:0] s1, s2;

  always_comb begin
    act      = (h_cnt >= HB) && (v_cnt >= VB);
    hsync_on = (h_cnt >= HS0) && (h_cnt < HS1);
    vsync_on = (v_cnt >= VS0) && (v_cnt < VS1);
    first_ln = act && (h_cnt == HB);
    first_px = first_ln && (v_cnt == VB);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (restart) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      h_cnt <= (h_cnt == HT1) ? '0 : h_cnt + 1'b1;
      if (h_cnt == HT1) v_cnt <= (v_cnt == VT1) ? '0 : v_cnt + 1'b1;
    end

  // Stage 1: s1 = {act, hsync_on, vsync_on, first_px, first_ln}; coordinates hold through blanking.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1       <= '0;
      active_x <= '0;
      active_y <= '0;
    end else if (restart) begin
      s1 <= '0;
    end else if (en) begin
      s1 <= {act, hsync_on, vsync_on, first_px, first_ln};
      if (act) begin
        active_x <= h_cnt - HB;
        active_y <= v_cnt - VB;
      end
    end

  assign req = s1[4];

  if (PREFETCH == 0) begin : g_wire
    assign s2 = s1;
  end else begin : g_dly
    logic [4:0] dly [PREFETCH];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < PREFETCH; i++) dly[i] <= '0;
      end else if (restart) begin
        for (int i = 0; i < PREFETCH; i++) dly[i] <= '0;
      end else if (en) begin
        dly[0] <= s1;
        for (int i = 1; i < PREFETCH; i++) dly[i] <= dly[i-1];
      end
    assign s2 = dly[PREFETCH-1];
  end

  assign de          = s2[4];
  assign hs          = s2[3] ? HS_POL : ~HS_POL;
  assign vs          = s2[2] ? VS_POL : ~VS_POL;
  assign frame_start = s2[1];
  assign line_start  = s2[0];
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of three generator variants (PREFETCH 0/3, inverted syncs)
// against a position model on a 14x8 raster.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst, en, restart;
  wire [5:0] o0, o3, on;
  wire [5:0] ax0, ay0, ax3, ay3, axn, ayn;
  wire [53:0] obs = {o0, o3, on, ax0, ay0, ax3, ay3, axn, ayn};
  int k, checks, errors;
  logic [5:0] eax, eay;

  always #5 clk = ~clk;

  video_timing_gen #(.CNT_W(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .hs(o0[3]), .vs(o0[2]), .de(o0[4]),
    .frame_start(o0[1]), .line_start(o0[0]), .req(o0[5]), .active_x(ax0), .active_y(ay0));
  video_timing_gen #(.CNT_W(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .hs(o3[3]), .vs(o3[2]), .de(o3[4]),
    .frame_start(o3[1]), .line_start(o3[0]), .req(o3[5]), .active_x(ax3), .active_y(ay3));
  video_timing_gen #(.CNT_W(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(0)) dutn (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .hs(on[3]), .vs(on[2]), .de(on[4]),
    .frame_start(on[1]), .line_start(on[0]), .req(on[5]), .active_x(axn), .active_y(ayn));

  // {req, de, hs, vs, frame_start, line_start} after k enabled edges with delay d
  function automatic logic [5:0] exp_out(int kk, int d, bit pol);
    int q, h, v;
    logic r, a, hy, vy, f, l;
    r = 1'b0; a = 1'b0; hy = 1'b0; vy = 1'b0; f = 1'b0; l = 1'b0;
    if (kk - 1 >= 0) r = (((kk - 1) % 14) >= 6) && ((((kk - 1) / 14) % 8) >= 4);
    q = kk - 1 - d;
    if (q >= 0) begin
      h = q % 14; v = (q / 14) % 8;
      a = (h >= 6) && (v >= 4);
      hy = (h >= 2) && (h < 5);
      vy = (v >= 1) && (v < 3);
      f = a && (h == 6) && (v == 4);
      l = a && (h == 6);
    end
    return {r, a, pol ? hy : ~hy, pol ? vy : ~vy, f, l};
  endfunction

  function automatic logic [53:0] expv();
    return {exp_out(k, 0, 1'b1), exp_out(k, 3, 1'b1), exp_out(k, 0, 1'b0), eax, eay, eax, eay, eax, eay};
  endfunction

  task automatic step(input bit e, input bit r);
    int p;
    en = e; restart = r;
    @(posedge clk);
    if (rst || r) begin
      k = 0;
      if (rst) begin eax = '0; eay = '0; end
    end else if (e) begin
      k++;
      p = k - 1;
      if ((p % 14) >= 6 && ((p / 14) % 8) >= 4) begin
        eax = 6'((p % 14) - 6);
        eay = 6'(((p / 14) % 8) - 4);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL reset_hold got %h want %h", obs, expv()); end
    end
    rst = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL reset_model k=%0d got %h want %h", k, obs, expv()); end
      if (c == 62 || c == 63) begin
        checks++;
        if (o0[4] !== (c == 63)) begin errors++; $display("FAIL first_de c=%0d got %b want %b", c, o0[4], c == 63); end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (o0[3] !== (c >= 3 && c <= 5)) begin errors++; $display("FAIL hs_width c=%0d got %b want %b", c, o0[3], c >= 3 && c <= 5); end
      end
    end
  endtask

  task automatic test_free_run();
    int nde, nvs, nfs, nls, last_fs;
    logic prev_de;
    logic [5:0] prev_ax;
    nde = 0; nvs = 0; nfs = 0; nls = 0; last_fs = -1; prev_de = 1'b0; prev_ax = '0;
    for (int c = 0; c < 336; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL free_model k=%0d got %h want %h", k, obs, expv()); end
      nde += int'(o0[4]); nvs += int'(o0[2]); nfs += int'(o0[1]); nls += int'(o0[0]);
      if (o0[1]) begin
        if (last_fs >= 0) begin
          checks++;
          if (k - last_fs != 112) begin errors++; $display("FAIL fs_period got %0d want 112", k - last_fs); end
        end
        checks++;
        if (ay0 !== 6'd0) begin errors++; $display("FAIL fs_y got %0d want 0", ay0); end
        last_fs = k;
      end
      if (o0[4]) begin
        checks++;
        if (ax0 !== (prev_de ? prev_ax + 6'd1 : 6'd0)) begin errors++; $display("FAIL de_x got %0d want %0d", ax0, prev_de ? prev_ax + 6'd1 : 6'd0); end
      end
      prev_de = o0[4]; prev_ax = ax0;
    end
    checks++;
    if (nde != 96 || nvs != 84 || nfs != 3 || nls != 12) begin
      errors++; $display("FAIL frame_counts got de=%0d vs=%0d fs=%0d ls=%0d want 96 84 3 12", nde, nvs, nfs, nls);
    end
  endtask

  task automatic test_prefetch();
    logic [4:0] hist [224];
    logic prev_req;
    logic [5:0] prev_ax;
    prev_req = o3[5]; prev_ax = ax3;
    for (int c = 0; c < 224; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL pf_model k=%0d got %h want %h", k, obs, expv()); end
      hist[c] = {o3[5], o0[3:0]};
      if (c >= 3) begin
        checks++;
        if (o3[4:0] !== hist[c-3]) begin errors++; $display("FAIL pf_lead c=%0d got %b want %b", c, o3[4:0], hist[c-3]); end
      end
      if (o3[5]) begin
        checks++;
        if (ax3 !== (prev_req ? prev_ax + 6'd1 : 6'd0)) begin errors++; $display("FAIL pf_x got %0d want %0d", ax3, prev_req ? prev_ax + 6'd1 : 6'd0); end
      end
      prev_req = o3[5]; prev_ax = ax3;
    end
  endtask

  task automatic test_enable();
    logic [53:0] prev;
    bit e, seen;
    int gap, dcnt, nfr;
    seen = 1'b0; gap = 0; dcnt = 0; nfr = 0;
    for (int c = 0; c < 600; c++) begin
      e = ($urandom_range(3, 0) != 0);
      prev = obs;
      step(e, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL en_model k=%0d got %h want %h", k, obs, expv()); end
      if (!e) begin
        checks++;
        if (obs !== prev) begin errors++; $display("FAIL en_freeze got %h want %h", obs, prev); end
      end else begin
        if (o0[1]) begin
          if (seen) begin
            checks++; nfr++;
            if (gap != 112 || dcnt != 32) begin errors++; $display("FAIL en_frame got gap=%0d de=%0d want 112 32", gap, dcnt); end
          end
          seen = 1'b1; gap = 0; dcnt = 0;
        end
        gap++;
        dcnt += int'(o0[4]);
      end
    end
    checks++;
    if (nfr < 2) begin errors++; $display("FAIL en_frames got %0d want >=2", nfr); end
  endtask

  task automatic test_restart();
    int f0, f3;
    for (int m = 0; m < 3; m++) begin
      step(1'b1, 1'b1);
      for (int c = 0; c < 79; c++) begin
        step(1'b1, 1'b0);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL rs_pre k=%0d got %h want %h", k, obs, expv()); end
      end
      for (int c = 0; c < (m == 1 ? 10 : 1); c++) begin
        step(m != 2, 1'b1);
        checks++;
        if ({o0[5:2], o3[5:2]} !== 8'b0000_0000 || obs !== expv()) begin
          errors++; $display("FAIL rs_idle m=%0d got %h want %h", m, obs, expv());
        end
      end
      f0 = -1; f3 = -1;
      for (int c = 1; c <= 80; c++) begin
        step(1'b1, 1'b0);
        checks++;
        if (obs !== expv()) begin errors++; $display("FAIL rs_post k=%0d got %h want %h", k, obs, expv()); end
        if (o0[1] && f0 < 0) f0 = c;
        if (o3[1] && f3 < 0) f3 = c;
      end
      checks++;
      if (f0 != 63 || f3 != 66) begin errors++; $display("FAIL rs_fs m=%0d got %0d/%0d want 63/66", m, f0, f3); end
    end
  endtask

  task automatic test_polarity();
    step(1'b1, 1'b1);
    for (int c = 0; c < 64; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL pol_model k=%0d got %h want %h", k, obs, expv()); end
    end
    checks++;
    if (on[4] !== 1'b1) begin errors++; $display("FAIL pol_active got %b want 1", on[4]); end
    #2 rst = 1'b1;
    #1;
    k = 0; eax = '0; eay = '0;
    checks++;
    if (obs !== expv() || on[3:2] !== 2'b11) begin errors++; $display("FAIL async_rst got %h want %h", obs, expv()); end
    @(negedge clk);
    repeat (3) step(1'b1, 1'b0);
    rst = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL pol_rel k=%0d got %h want %h", k, obs, expv()); end
      if (c == 62 || c == 63) begin
        checks++;
        if (on[4] !== (c == 63)) begin errors++; $display("FAIL pol_first_de c=%0d got %b", c, on[4]); end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (on[3] !== !(c >= 3 && c <= 5)) begin errors++; $display("FAIL pol_hs c=%0d got %b", c, on[3]); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; k = 0; eax = '0; eay = '0;
    rst = 1'b1; en = 1'b0; restart = 1'b0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_prefetch();
    test_enable();
    test_restart();
    test_polarity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
